// File: rtl/scoreboard_pkg.sv
// Shared constants for the counter scoreboard: mode encodings and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scoreboard_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_DN3 = 2'b10,
    MODE_LD  = 2'b11
  } mode_e;

endpackage

// File: rtl/scoreboard_next.sv
// Next-state and flag computation for the scoreboard counter model.
// Latency: purely combinational.
// Backpressure: none; enable low yields hold with both flags cleared.
module scoreboard_next
  import scoreboard_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       modo,
  input  logic             enable,
  output logic [WIDTH-1:0] q_nxt,
  output logic             rco_nxt,
  output logic             load_nxt
);

  // Flags are taken from the pre-update value; unknown modes fall to hold.
  always_comb begin
    q_nxt    = q;
    rco_nxt  = 1'b0;
    load_nxt = 1'b0;
    if (enable) begin
      case (modo)
        MODE_UP: begin
          q_nxt   = q + 1'b1;
          rco_nxt = (q == {WIDTH{1'b1}});
        end
        MODE_DN: begin
          q_nxt   = q - 1'b1;
          rco_nxt = (q == {WIDTH{1'b0}});
        end
        MODE_DN3: begin
          // Subtracting the truncated constant stays correct modulo 2^WIDTH.
          q_nxt   = q - WIDTH'(3);
          rco_nxt = (32'(q) < 32'd3);
        end
        MODE_LD: begin
          q_nxt    = d;
          load_nxt = 1'b1;
        end
        default: begin
          q_nxt    = q;
          rco_nxt  = 1'b0;
          load_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Reference counter model: registers around scoreboard_next, async active-low reset.
// Latency: one cycle from sampled inputs to sb_Q/sb_RCO/sb_LOAD.
// Backpressure: none; ENABLE low holds the count and clears the flags.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] sb_D,
  input  logic [1:0]       sb_MODO,
  output logic [WIDTH-1:0] sb_Q,
  output logic             sb_RCO,
  output logic             sb_LOAD
);

  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;
  logic             load_nxt;

  scoreboard_next #(.WIDTH(WIDTH)) u_next (
    .q        (sb_Q),
    .d        (sb_D),
    .modo     (sb_MODO),
    .enable   (ENABLE),
    .q_nxt    (q_nxt),
    .rco_nxt  (rco_nxt),
    .load_nxt (load_nxt)
  );

  // Output registers; reset clears count and flags without waiting for clk.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      sb_Q    <= '0;
      sb_RCO  <= 1'b0;
      sb_LOAD <= 1'b0;
    end else begin
      sb_Q    <= q_nxt;
      sb_RCO  <= rco_nxt;
      sb_LOAD <= load_nxt;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed vector table, reset sequences, random vs model.
// Latency: expects outputs one edge after inputs are sampled.
// Backpressure: n/a.
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         RESET;
  logic         ENABLE;
  logic [W-1:0] sb_D;
  logic [1:0]   sb_MODO;
  logic [W-1:0] sb_Q;
  logic         sb_RCO;
  logic         sb_LOAD;

  int n_cmp;
  int n_bad;

  // Reference model state (plain integers, modular arithmetic).
  int m_q;
  int m_rco;
  int m_load;

  scoreboard #(.WIDTH(W)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .sb_D    (sb_D),
    .sb_MODO (sb_MODO),
    .sb_Q    (sb_Q),
    .sb_RCO  (sb_RCO),
    .sb_LOAD (sb_LOAD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [1:0]   modo;
    logic [W-1:0] d;
    int           exp_q;
    int           exp_rco;
    int           exp_load;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int q_exp, input int rco_exp, input int load_exp);
    n_cmp++;
    if (int'(sb_Q) != q_exp || int'(sb_RCO) != rco_exp || int'(sb_LOAD) != load_exp) begin
      n_bad++;
      $display("FAIL %s: got q=%0d rco=%0d load=%0d, want q=%0d rco=%0d load=%0d",
               nm, sb_Q, sb_RCO, sb_LOAD, q_exp, rco_exp, load_exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic en, input logic [1:0] m, input logic [W-1:0] d);
    ENABLE  = en;
    sb_MODO = m;
    sb_D    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic en, input logic [1:0] m, input int d);
    m_rco  = 0;
    m_load = 0;
    if (en) begin
      if (m == 2'b00) begin
        m_rco = (m_q == MOD - 1) ? 1 : 0;
        m_q   = (m_q + 1) % MOD;
      end else if (m == 2'b01) begin
        m_rco = (m_q == 0) ? 1 : 0;
        m_q   = (m_q + MOD - 1) % MOD;
      end else if (m == 2'b10) begin
        m_rco = (m_q < 3) ? 1 : 0;
        m_q   = (m_q + MOD - 3) % MOD;
      end else begin
        m_q    = d;
        m_load = 1;
      end
    end
  endtask

  task automatic add(input logic en, input logic [1:0] m, input int d,
                     input int q, input int rco, input int ld);
    vec_t v;
    v.en = en; v.modo = m; v.d = W'(d);
    v.exp_q = q; v.exp_rco = rco; v.exp_load = ld;
    vecs.push_back(v);
  endtask

  initial begin
    logic         r_en;
    logic [1:0]   r_m;
    logic [W-1:0] r_d;

    n_cmp = 0;
    n_bad = 0;

    // Expected values written out from the mode rules.
    add(1, 2'b11, 14, 14, 0, 1);  // load 14
    add(1, 2'b00,  0, 15, 0, 0);  // up 14->15
    add(1, 2'b00,  0,  0, 1, 0);  // up wrap 15->0
    add(1, 2'b00,  0,  1, 0, 0);
    add(1, 2'b01,  0,  0, 0, 0);  // down 1->0
    add(1, 2'b01,  0, 15, 1, 0);  // down wrap 0->15
    add(1, 2'b01,  0, 14, 0, 0);
    add(1, 2'b11,  5,  5, 0, 1);
    add(1, 2'b10,  0,  2, 0, 0);  // 5-3
    add(1, 2'b10,  0, 15, 1, 0);  // 2-3 borrows
    add(1, 2'b10,  0, 12, 0, 0);
    add(1, 2'b11, 10, 10, 0, 1);  // back-to-back loads
    add(1, 2'b11, 10, 10, 0, 1);
    add(1, 2'b00,  3, 11, 0, 0);
    add(1, 2'b11,  7,  7, 0, 1);
    add(0, 2'b00,  0,  7, 0, 0);  // hold x3
    add(0, 2'b00,  0,  7, 0, 0);
    add(0, 2'b11,  3,  7, 0, 0);
    add(1, 2'b11, 15, 15, 0, 1);
    add(0, 2'b00,  0, 15, 0, 0);  // hold at max: no carry
    add(1, 2'b00,  0,  0, 1, 0);
    add(1, 2'b11,  2,  2, 0, 1);
    add(1, 2'b10,  0, 15, 1, 0);  // borrow from 2
    add(1, 2'b11,  3,  3, 0, 1);
    add(1, 2'b10,  0,  0, 0, 0);  // exactly 3: no borrow

    RESET   = 1'b0;
    ENABLE  = 1'b1;
    sb_MODO = 2'b11;
    sb_D    = 4'h9;
    #2;
    check("reset_async_initial", 0, 0, 0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 0, 0, 0);
    @(negedge clk);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].modo, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_rco, vecs[i].exp_load);
    end

    // Mid-cycle reset at q=9 must clear outputs before the next edge.
    apply(1, 2'b11, 9);
    check("load9_before_reset", 9, 0, 1);
    @(negedge clk);
    RESET = 1'b0;
    #1;
    check("reset_mid_cycle", 0, 0, 0);
    ENABLE = 1'b1; sb_MODO = 2'b11; sb_D = 4'hF;
    @(posedge clk); #1;
    check("reset_ignores_load", 0, 0, 0);
    @(negedge clk);
    RESET = 1'b1;
    apply(1, 2'b00, 0);
    check("first_edge_after_reset", 1, 0, 0);

    // Random run against the model, with occasional mid-cycle resets.
    m_q = 1; m_rco = 0; m_load = 0;
    for (int i = 0; i < 100; i++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_m  = 2'($urandom_range(0, 3));
      r_d  = W'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        RESET = 1'b0;
        #1;
        m_q = 0; m_rco = 0; m_load = 0;
        check($sformatf("rand_reset%0d", i), m_q, m_rco, m_load);
        RESET = 1'b1;
      end
      apply(r_en, r_m, r_d);
      model_step(r_en, r_m, int'(r_d));
      check($sformatf("rand%0d", i), m_q, m_rco, m_load);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
